// File: rtl/axi_pkg.sv
// Shared AXI encodings and write-arbiter FSM states.
// No ports: types only, imported by the arbiter/mux files.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping.
// Ports: req_i (requests), ptr_i (last owner index), gnt_o (one-hot pick).
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   // Scan from farthest to nearest so the nearest requester after
   // ptr_i overwrites any earlier candidate.
   always_comb begin
      gnt_o = '0;
      sum   = '0;
      idx   = '0;
      for (int k = N; k >= 1; k--) begin
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_wr_arbiter_mux.sv
// NUM_M-to-1 AXI4 write-path arbiter/mux, one transaction in flight.
// Ports: m_axi_aw*/w*/b* flattened per master, s_axi_* slave side,
// grant (registered one-hot owner), wlast_err (WLAST/AWLEN mismatch pulse).
module axi_wr_arbiter_mux
   import axi_pkg::*;
#(
   parameter int NUM_M  = 4,
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [NUM_M*ID_W-1:0]      m_axi_awid,
   input  logic [NUM_M*ADDR_W-1:0]    m_axi_awaddr,
   input  logic [NUM_M*LEN_W-1:0]     m_axi_awlen,
   input  logic [NUM_M*3-1:0]         m_axi_awsize,
   input  logic [NUM_M*2-1:0]         m_axi_awburst,
   input  logic [NUM_M-1:0]           m_axi_awvalid,
   output logic [NUM_M-1:0]           m_axi_awready,
   input  logic [NUM_M*DATA_W-1:0]    m_axi_wdata,
   input  logic [NUM_M*DATA_W/8-1:0]  m_axi_wstrb,
   input  logic [NUM_M-1:0]           m_axi_wlast,
   input  logic [NUM_M-1:0]           m_axi_wvalid,
   output logic [NUM_M-1:0]           m_axi_wready,
   output logic [NUM_M*ID_W-1:0]      m_axi_bid,
   output logic [NUM_M*2-1:0]         m_axi_bresp,
   output logic [NUM_M-1:0]           m_axi_bvalid,
   input  logic [NUM_M-1:0]           m_axi_bready,
   output logic [ID_W-1:0]            s_axi_awid,
   output logic [ADDR_W-1:0]          s_axi_awaddr,
   output logic [LEN_W-1:0]           s_axi_awlen,
   output logic [2:0]                 s_axi_awsize,
   output logic [1:0]                 s_axi_awburst,
   output logic                       s_axi_awvalid,
   input  logic                       s_axi_awready,
   output logic [DATA_W-1:0]          s_axi_wdata,
   output logic [DATA_W/8-1:0]        s_axi_wstrb,
   output logic                       s_axi_wlast,
   output logic                       s_axi_wvalid,
   input  logic                       s_axi_wready,
   input  logic [ID_W-1:0]            s_axi_bid,
   input  logic [1:0]                 s_axi_bresp,
   input  logic                       s_axi_bvalid,
   output logic                       s_axi_bready,
   output logic [NUM_M-1:0]           grant,
   output logic                       wlast_err
);

   localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW = DATA_W / 8;

   wr_state_e        state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d, pick;
   logic [PW-1:0]    ptr_q, ptr_d, gidx;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W:0]   beat_q, beat_d;
   logic             err_q, err_d;
   logic             sel_awvalid, sel_wvalid, sel_bready;
   logic             aw_hs, w_hs, b_hs;

   rr_arbiter #(.N(NUM_M)) u_arb (
      .req_i (m_axi_awvalid),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   // AND-OR payload mux; a zero grant yields all-zero slave payload.
   always_comb begin
      s_axi_awid    = '0;
      s_axi_awaddr  = '0;
      s_axi_awlen   = '0;
      s_axi_awsize  = '0;
      s_axi_awburst = '0;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wlast   = 1'b0;
      gidx          = '0;
      for (int i = 0; i < NUM_M; i++) begin
         s_axi_awid    = s_axi_awid |
                         (m_axi_awid[i*ID_W +: ID_W] & {ID_W{grant_q[i]}});
         s_axi_awaddr  = s_axi_awaddr |
                         (m_axi_awaddr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[i]}});
         s_axi_awlen   = s_axi_awlen |
                         (m_axi_awlen[i*LEN_W +: LEN_W] & {LEN_W{grant_q[i]}});
         s_axi_awsize  = s_axi_awsize |
                         (m_axi_awsize[i*3 +: 3] & {3{grant_q[i]}});
         s_axi_awburst = s_axi_awburst |
                         (m_axi_awburst[i*2 +: 2] & {2{grant_q[i]}});
         s_axi_wdata   = s_axi_wdata |
                         (m_axi_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
         s_axi_wstrb   = s_axi_wstrb |
                         (m_axi_wstrb[i*SW +: SW] & {SW{grant_q[i]}});
         s_axi_wlast   = s_axi_wlast | (m_axi_wlast[i] & grant_q[i]);
         if (grant_q[i]) gidx = PW'(i);
      end
   end

   assign sel_awvalid   = |(m_axi_awvalid & grant_q);
   assign sel_wvalid    = |(m_axi_wvalid & grant_q);
   assign sel_bready    = |(m_axi_bready & grant_q);

   assign s_axi_awvalid = (state_q == ST_ADDR) && sel_awvalid;
   assign s_axi_wvalid  = (state_q == ST_DATA) && sel_wvalid;
   assign s_axi_bready  = (state_q == ST_RESP) && sel_bready;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign b_hs  = s_axi_bvalid && s_axi_bready;

   for (genvar i = 0; i < NUM_M; i++) begin : g_m
      logic in_resp;
      assign in_resp = grant_q[i] && (state_q == ST_RESP);
      assign m_axi_awready[i] = grant_q[i] && (state_q == ST_ADDR) && s_axi_awready;
      assign m_axi_wready[i]  = grant_q[i] && (state_q == ST_DATA) && s_axi_wready;
      assign m_axi_bvalid[i]  = in_resp && s_axi_bvalid;
      assign m_axi_bid[i*ID_W +: ID_W] = in_resp ? s_axi_bid : '0;
      assign m_axi_bresp[i*2 +: 2]     = in_resp ? s_axi_bresp : '0;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|m_axi_awvalid) begin
               grant_d = pick;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (aw_hs) begin
               len_d   = s_axi_awlen;
               beat_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               beat_d = beat_q + 1'b1;
               // beat_q is the 0-based index of the beat being accepted
               err_d  = s_axi_wlast ? (beat_q != {1'b0, len_q})
                                    : (beat_q == {1'b0, len_q});
               if (s_axi_wlast) state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (b_hs) begin
               ptr_d   = gidx;
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= PW'(NUM_M - 1);
         len_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   assign grant     = grant_q;
   assign wlast_err = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter_mux.sv
// Randomized bench for axi_wr_arbiter_mux against a transaction-level model.
// Drives masters and slave at negedge, checks outputs 1ns later.
module tb_axi_wr_arbiter_mux;

   localparam int NUM_M  = 4;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;
   localparam int SW     = DATA_W / 8;
   localparam int MAXB   = 16;
   localparam int NCYC   = 4000;

   logic                      aclk, areset;
   logic [NUM_M*ID_W-1:0]     m_awid;
   logic [NUM_M*ADDR_W-1:0]   m_awaddr;
   logic [NUM_M*LEN_W-1:0]    m_awlen;
   logic [NUM_M*3-1:0]        m_awsize;
   logic [NUM_M*2-1:0]        m_awburst;
   logic [NUM_M-1:0]          m_awvalid, m_awready;
   logic [NUM_M*DATA_W-1:0]   m_wdata;
   logic [NUM_M*SW-1:0]       m_wstrb;
   logic [NUM_M-1:0]          m_wlast, m_wvalid, m_wready;
   logic [NUM_M*ID_W-1:0]     m_bid;
   logic [NUM_M*2-1:0]        m_bresp;
   logic [NUM_M-1:0]          m_bvalid, m_bready;
   logic [ID_W-1:0]           s_awid;
   logic [ADDR_W-1:0]         s_awaddr;
   logic [LEN_W-1:0]          s_awlen;
   logic [2:0]                s_awsize;
   logic [1:0]                s_awburst;
   logic                      s_awvalid, s_awready;
   logic [DATA_W-1:0]         s_wdata;
   logic [SW-1:0]             s_wstrb;
   logic                      s_wlast, s_wvalid, s_wready;
   logic [ID_W-1:0]           s_bid;
   logic [1:0]                s_bresp;
   logic                      s_bvalid, s_bready;
   logic [NUM_M-1:0]          grant;
   logic                      wlast_err;

   axi_wr_arbiter_mux #(
      .NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W),
      .DATA_W(DATA_W), .LEN_W(LEN_W)
   ) dut (
      .aclk(aclk), .areset(areset),
      .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
      .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst),
      .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
      .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
      .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
      .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
      .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
      .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
      .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst),
      .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
      .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
      .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
      .s_axi_bid(s_bid), .s_axi_bresp(s_bresp),
      .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
      .grant(grant), .wlast_err(wlast_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // master-side transaction store
   bit               has [NUM_M];
   bit               aw_sent [NUM_M];
   int               nb [NUM_M];
   int               bsent [NUM_M];
   int               gap [NUM_M];
   logic [ID_W-1:0]   t_id [NUM_M];
   logic [ADDR_W-1:0] t_addr [NUM_M];
   logic [LEN_W-1:0]  t_len [NUM_M];
   logic [2:0]        t_size [NUM_M];
   logic [1:0]        t_burst [NUM_M];
   logic [DATA_W-1:0] t_dat [NUM_M][MAXB];
   logic [SW-1:0]     t_strb [NUM_M][MAXB];

   // slave responder
   bit              bpend;
   logic [ID_W-1:0] sb_id, aw_cap;
   logic [1:0]      sb_resp;

   // reference model: owner of the locked grant and its progress
   int owner, last_own, beat, nrst;
   bit aw_done, wl_done, err_pend;

   int n_cmp, n_bad;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_M-1:0] req, input int last);
      int j;
      for (int k = 1; k <= NUM_M; k++) begin
         j = (last + k) % NUM_M;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic new_txn(input int i);
      int l, lp;
      l  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : 0;
      lp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, l + 2)) : l;
      has[i]     = 1'b1;
      aw_sent[i] = 1'b0;
      bsent[i]   = 0;
      nb[i]      = lp + 1;
      t_id[i]    = ID_W'($urandom);
      t_addr[i]  = ADDR_W'($urandom);
      t_len[i]   = LEN_W'(l);
      t_size[i]  = 3'($urandom);
      t_burst[i] = 2'($urandom_range(0, 2));
      for (int k = 0; k < MAXB; k++) begin
         t_dat[i][k]  = DATA_W'($urandom);
         t_strb[i][k] = SW'($urandom);
      end
   endtask

   task automatic drive_quiet();
      m_awvalid = '0;
      m_wvalid  = '0;
      m_wlast   = '0;
      m_bready  = '0;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_bid     = '0;
      s_bresp   = '0;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_M; i++) begin
         has[i] = 1'b0;
         gap[i] = 0;
      end
      bpend    = 1'b0;
      owner    = -1;
      last_own = NUM_M - 1;
      beat     = 0;
      aw_done  = 1'b0;
      wl_done  = 1'b0;
      err_pend = 1'b0;
   endtask

   initial begin
      logic [NUM_M-1:0]      eg, e_awr, e_wr, e_bv;
      logic [NUM_M*ID_W-1:0] e_bid;
      logic [NUM_M*2-1:0]    e_bresp;
      bit pa, pw, pb, e_saw, e_sw, e_sb, e_aw_hs, e_w_hs, wl, awv;

      n_cmp = 0;
      n_bad = 0;
      nrst  = 0;
      for (int i = 0; i < NUM_M; i++) begin
         t_id[i] = '0; t_addr[i] = '0; t_len[i] = '0;
         t_size[i] = '0; t_burst[i] = '0; nb[i] = 0; bsent[i] = 0;
         aw_sent[i] = 1'b0;
         for (int k = 0; k < MAXB; k++) begin
            t_dat[i][k] = '0; t_strb[i][k] = '0;
         end
      end
      sb_id = '0; sb_resp = '0; aw_cap = '0;
      m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
      m_awburst = '0; m_wdata = '0; m_wstrb = '0;
      clear_all();
      areset = 1'b1;
      drive_quiet();
      repeat (3) @(negedge aclk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge aclk);
         // abandon an 8-beat burst after its second beat
         if (owner >= 0 && aw_done && !wl_done && beat == 2 &&
             t_len[owner] == LEN_W'(7) && nrst < 3) begin
            areset = 1'b1;
            drive_quiet();
            #1;
            nrst++;
            clear_all();
            continue;
         end
         areset = 1'b0;

         for (int i = 0; i < NUM_M; i++) begin
            if (!has[i]) begin
               if (gap[i] > 0) gap[i]--;
               else if ($urandom_range(0, 1) == 1) new_txn(i);
            end
            awv = has[i] && !aw_sent[i];
            if (awv && owner != i && $urandom_range(0, 7) == 0) awv = 1'b0;
            m_awvalid[i] = awv;
            m_awid[i*ID_W +: ID_W]       = t_id[i];
            m_awaddr[i*ADDR_W +: ADDR_W] = t_addr[i];
            m_awlen[i*LEN_W +: LEN_W]    = t_len[i];
            m_awsize[i*3 +: 3]           = t_size[i];
            m_awburst[i*2 +: 2]          = t_burst[i];
            m_wvalid[i] = has[i] && bsent[i] < nb[i] &&
                          $urandom_range(0, 3) != 0;
            m_wdata[i*DATA_W +: DATA_W] = t_dat[i][bsent[i] % MAXB];
            m_wstrb[i*SW +: SW]         = t_strb[i][bsent[i] % MAXB];
            m_wlast[i]  = has[i] && bsent[i] == nb[i] - 1;
            m_bready[i] = $urandom_range(0, 4) > 1;
         end
         s_awready = $urandom_range(0, 1) == 1;
         s_wready  = $urandom_range(0, 9) > 2;
         s_bvalid  = bpend;
         s_bid     = bpend ? sb_id : ID_W'($urandom);
         s_bresp   = bpend ? sb_resp : 2'($urandom);
         #1;

         pa = owner >= 0 && !aw_done;
         pw = owner >= 0 && aw_done && !wl_done;
         pb = owner >= 0 && wl_done;
         eg = '0; e_awr = '0; e_wr = '0; e_bv = '0;
         e_bid = '0; e_bresp = '0;
         e_saw = 1'b0; e_sw = 1'b0; e_sb = 1'b0;
         if (owner >= 0) begin
            eg[owner] = 1'b1;
            if (pa) e_awr[owner] = s_awready;
            if (pw) e_wr[owner] = s_wready;
            if (pb) begin
               e_bv[owner] = s_bvalid;
               e_bid[owner*ID_W +: ID_W] = s_bid;
               e_bresp[owner*2 +: 2] = s_bresp;
            end
            e_saw = pa && m_awvalid[owner];
            e_sw  = pw && m_wvalid[owner];
            e_sb  = pb && m_bready[owner];
         end
         chk("grant", grant, eg);
         chk("wlast_err", wlast_err, err_pend);
         chk("m_awready", m_awready, e_awr);
         chk("m_wready", m_wready, e_wr);
         chk("m_bvalid", m_bvalid, e_bv);
         chk("m_bid_bresp", {m_bid, m_bresp}, {e_bid, e_bresp});
         chk("s_valid_ready", {s_awvalid, s_wvalid, s_bready},
             {e_saw, e_sw, e_sb});
         if (owner < 0)
            chk("idle_slave", {s_awid, s_awaddr, s_awlen, s_awsize,
                s_awburst, s_awvalid, s_wdata, s_wstrb, s_wlast,
                s_wvalid, s_bready}, '0);
         e_aw_hs = e_saw && s_awready;
         e_w_hs  = e_sw && s_wready;
         wl      = 1'b0;
         if (e_aw_hs)
            chk("aw_payload",
                {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst},
                {t_id[owner], t_addr[owner], t_len[owner],
                 t_size[owner], t_burst[owner]});
         if (e_w_hs) begin
            wl = beat == nb[owner] - 1;
            chk("w_payload", {s_wdata, s_wstrb, s_wlast},
                {t_dat[owner][beat % MAXB], t_strb[owner][beat % MAXB], wl});
         end

         for (int i = 0; i < NUM_M; i++) begin
            if (m_awvalid[i] && m_awready[i]) aw_sent[i] = 1'b1;
            if (m_wvalid[i] && m_wready[i]) bsent[i]++;
            if (m_bvalid[i] && m_bready[i]) begin
               has[i] = 1'b0;
               gap[i] = $urandom_range(0, 3);
            end
         end
         if (s_awvalid && s_awready) aw_cap = s_awid;
         if (s_bvalid && s_bready) bpend = 1'b0;
         if (s_wvalid && s_wready && s_wlast) begin
            bpend   = 1'b1;
            sb_id   = aw_cap;
            sb_resp = 2'($urandom);
         end

         err_pend = 1'b0;
         if (owner < 0) begin
            if (|m_awvalid) begin
               owner   = rr_pick(m_awvalid, last_own);
               aw_done = 1'b0;
               wl_done = 1'b0;
               beat    = 0;
            end
         end else begin
            if (e_aw_hs) aw_done = 1'b1;
            if (e_w_hs) begin
               err_pend = (wl && beat != int'(t_len[owner])) ||
                          (!wl && beat == int'(t_len[owner]));
               beat++;
               if (wl) wl_done = 1'b1;
            end
            if (pb && s_bvalid && m_bready[owner]) begin
               last_own = owner;
               owner    = -1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
